// File: rtl/kfps2kb_xt_keybuf_pkg.sv
// Shared state encodings and keycode constants for the XT keyboard buffer stage.
package kfps2kb_xt_pkg;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_ACK,
        IN_WAIT
    } in_state_t;

    typedef enum logic {
        OUT_EMPTY,
        OUT_VALID
    } out_state_t;

    localparam logic [7:0] KEYCODE_OVERRUN = 8'hFF;
    localparam logic [7:0] KEYCODE_NONE    = 8'h00;

endpackage

// File: rtl/kfps2kb_xt_keybuf_if.sv
// Converter-side keycode handshake plus the XT PPI keyboard port, bundled for the keyboard buffer.
interface kfps2kb_xt_keybuf_if;

    logic       ps2_irq;
    logic [7:0] ps2_keycode;
    logic       ps2_clear_keycode;
    logic       kbd_clock_low;
    logic       kbd_clear;
    logic       irq;
    logic [7:0] keycode;

    // master: converter + PPI side driving the buffer; slave: the buffer itself.
    modport master (
        output ps2_irq, ps2_keycode, kbd_clock_low, kbd_clear,
        input  ps2_clear_keycode, irq, keycode
    );

    modport slave (
        input  ps2_irq, ps2_keycode, kbd_clock_low, kbd_clear,
        output ps2_clear_keycode, irq, keycode
    );

endinterface

// File: rtl/kfps2kb_sync_fifo.sv
// Synchronous byte FIFO with flush and occupancy count; pop_data shows the head entry while not empty.
module kfps2kb_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic                pop,
    output logic [7:0]          pop_data,
    input  logic                flush,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees its slot in the same cycle, so a full FIFO still takes a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so pointers and count all update from pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push && reset_n && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);

endmodule

// File: rtl/kfps2kb_xt_keybuf.sv
// XT keyboard port buffer: converter intake FSM, FIFO, PPI output FSM and keyboard soft-reset emulation.
// Build option KFPS2KB_XT_KEYBUF_OVERRUN_EN reserves the last FIFO slot for an 8'hFF overrun marker.
module kfps2kb_xt_keybuf
    import kfps2kb_xt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2   = 3,
    parameter logic [15:0] RESET_HOLD_CYCLES = 16'd2000,
    parameter logic [7:0]  SELFTEST_CODE     = 8'hAA
) (
    input logic                clock,
    input logic                reset_n,
    kfps2kb_xt_keybuf_if.slave bus
);

    localparam int unsigned CW = FIFO_DEPTH_LOG2 + 1;

    in_state_t  in_state, in_next;
    out_state_t out_state, out_next;

    logic [15:0]   hold_cnt;
    logic          hold_active;
    logic          selftest_pend;
    logic [7:0]    key_q;
    logic          in_take;
    logic          push_req;
    logic [7:0]    push_byte;
    logic          fifo_push;
    logic [7:0]    fifo_data;
    logic          fifo_pop;
    logic [7:0]    pop_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_room;
    logic [CW-1:0] fifo_count;

    // Saturating count of consecutive clock-low cycles; the self-test code follows the release.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_cnt      <= '0;
            selftest_pend <= 1'b0;
        end else begin
            if (!bus.kbd_clock_low)  hold_cnt <= '0;
            else if (!hold_active)   hold_cnt <= hold_cnt + 16'd1;
            selftest_pend <= hold_active && !bus.kbd_clock_low;
        end
    end

    assign hold_active = (hold_cnt == RESET_HOLD_CYCLES);

    // Intake FSM; a pending self-test push takes the FIFO port, so the converter simply waits a cycle.
    assign in_take = (in_state == IN_IDLE) && bus.ps2_irq && !selftest_pend;

    always_ff @(posedge clock) begin
        if (!reset_n) in_state <= IN_IDLE;
        else          in_state <= in_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves in_next unassigned (no latch).
        in_next = in_state;
        unique case (in_state)
            IN_IDLE: if (in_take)      in_next = IN_ACK;
            IN_ACK:                    in_next = IN_WAIT;
            IN_WAIT: if (!bus.ps2_irq) in_next = IN_IDLE;
            default:                   in_next = IN_IDLE;
        endcase
    end

    always_comb begin
        bus.ps2_clear_keycode = (in_state == IN_ACK);
    end

    // Push path: bytes arriving during a held keyboard reset are acked but discarded.
    assign push_req  = selftest_pend || (in_take && !hold_active);
    assign push_byte = selftest_pend ? SELFTEST_CODE : bus.ps2_keycode;
    assign fifo_room = !fifo_full || fifo_pop;

`ifdef KFPS2KB_XT_KEYBUF_OVERRUN_EN
    localparam logic [CW-1:0] DEPTH_M1 = CW'((1 << FIFO_DEPTH_LOG2) - 1);
    logic [CW-1:0] occ_eff;

    // Occupancy after this cycle's pop decides whether the byte lands in the reserved slot.
    assign occ_eff = fifo_count - {{FIFO_DEPTH_LOG2{1'b0}}, fifo_pop};

    always_comb begin
        fifo_push = 1'b0;
        fifo_data = push_byte;
        if (push_req && fifo_room) begin
            fifo_push = 1'b1;
            if (occ_eff == DEPTH_M1) fifo_data = KEYCODE_OVERRUN;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^fifo_count;

    always_comb begin
        fifo_push = push_req && fifo_room;
        fifo_data = push_byte;
    end
`endif

    kfps2kb_sync_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .flush     (hold_active),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Output FSM: one code presented at a time, released only by the BIOS clear strobe.
    assign fifo_pop = (out_state == OUT_EMPTY) && !fifo_empty && !bus.kbd_clear && !hold_active;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_state <= OUT_EMPTY;
            key_q     <= KEYCODE_NONE;
        end else begin
            out_state <= out_next;
            if (bus.kbd_clear || hold_active) key_q <= KEYCODE_NONE;
            else if (fifo_pop)                key_q <= pop_data;
        end
    end

    always_comb begin
        out_next = out_state;
        if (bus.kbd_clear || hold_active) out_next = OUT_EMPTY;
        else if (fifo_pop)                out_next = OUT_VALID;
    end

    always_comb begin
        bus.irq     = (out_state == OUT_VALID);
        bus.keycode = key_q;
    end

endmodule
